bcd_conv_sched: RTL and testbench

//  Shared iterative binary-to-BCD converter with a two-port round-robin scheduler.
//  - Two requesters each present a BIN_W-bit value; one is granted and its value latched.
//  - Conversion uses shift-add-3 (double dabble), one bit per clock: small area, no long comb path.
//  - Result is a packed BCD word plus a one-cycle done pulse tagged with the requester id.
//  - Sits between the measurement/counter logic and the 7-segment display drivers.

---
 rtl/bcd_conv_sched.sv | 147 ++++++++++++++
 tb/tb_bcd_conv_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_sched.sv
// Shared double-dabble binary-to-BCD converter serving two requesters
// through a round-robin scheduler; one result bit is consumed per clock.
module bcd_conv_sched #(
  parameter int unsigned BIN_W  = 17,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [BIN_W-1:0]      bin0,
  input  logic                  req1,
  input  logic [BIN_W-1:0]      bin1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  busy,
  output logic                  done,
  output logic                  done_id,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   sr_q, sr_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rr_q, rr_d;
  logic               id_q, id_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               done_id_q, done_id_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_shift;
  logic               grant1;

  // Add-3 correction on every digit that would overflow past 9 when doubled
  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_shift = {acc_adj[BCD_W-2:0], sr_q[BIN_W-1]};
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    id_d      = id_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    bcd_d     = bcd_q;
    // rr_q names the requester preferred when both are pending
    grant1    = req1 && (!req0 || rr_q);

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          id_d    = grant1;
          sr_d    = grant1 ? bin1 : bin0;
          acc_d   = '0;
          cnt_d   = '0;
          ack0_d  = !grant1;
          ack1_d  = grant1;
          busy_d  = 1'b1;
          rr_d    = !grant1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        acc_d = acc_shift;
        sr_d  = {sr_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bcd_d     = acc_shift;
          done_id_d = id_q;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      rr_q      <= 1'b0;
      id_q      <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      bcd_q     <= bcd_d;
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign bcd     = bcd_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench for bcd_conv_sched: directed scenarios plus randomized
// jobs compared against a decimal-arithmetic reference and a round-robin model.
module tb_bcd_conv_sched;

  localparam int unsigned BIN_W  = 17;
  localparam int unsigned DIGITS = 6;
  localparam int unsigned BCD_W  = 4 * DIGITS;

  logic               clk = 1'b0;
  logic               reset;
  logic               req0, req1;
  logic [BIN_W-1:0]   bin0, bin1;
  logic               ack0, ack1, busy, done, done_id;
  logic [BCD_W-1:0]   bcd;

  int errors = 0;
  int checks = 0;
  bit pref   = 1'b0;

  always #5 clk = ~clk;

  bcd_conv_sched #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .bin0    (bin0),
    .req1    (req1),
    .bin1    (bin1),
    .ack0    (ack0),
    .ack1    (ack1),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .bcd     (bcd)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
    logic [BCD_W-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    #1;
    check_val("rst_bcd",     32'(bcd),     32'h0);
    check_val("rst_done",    32'(done),    32'h0);
    check_val("rst_done_id", 32'(done_id), 32'h0);
    check_val("rst_busy",    32'(busy),    32'h0);
    check_val("rst_ack",     32'({ack1, ack0}), 32'h0);
    step();
    step();
    reset = 1'b1;
    pref  = 1'b0;
  endtask

  task automatic request(input bit id, input logic [BIN_W-1:0] v);
    if (id) begin
      req1 = 1'b1;
      bin1 = v;
    end else begin
      req0 = 1'b1;
      bin0 = v;
    end
  endtask

  // Wait for the ack of the requester the model expects to be granted
  task automatic wait_ack(input bit id);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      step();
      if (ack0 || ack1) begin
        got = 1'b1;
        check_val("ack_overlap", 32'(ack0 & ack1), 32'h0);
        check_val("ack_id",      32'(ack1),        32'(id));
        check_val("busy_at_ack", 32'(busy),        32'h1);
        if (id) req1 = 1'b0;
        else    req0 = 1'b0;
        pref = !id;
      end
    end
    if (!got) check_val("ack_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_done(input logic [BCD_W-1:0] exp, input bit id, input int lat);
    bit got;
    int n;
    got = 1'b0;
    n   = 0;
    while (!got && n < 64) begin
      step();
      n++;
      check_val("no_ack_busy", 32'(ack0 | ack1), 32'h0);
      check_val("busy_hold",   32'(busy),        32'h1);
      if (done) got = 1'b1;
    end
    if (!got) begin
      check_val("done_timeout", 32'h0, 32'h1);
    end else begin
      check_val("latency", 32'(n),       32'(lat));
      check_val("bcd",     32'(bcd),     32'(exp));
      check_val("done_id", 32'(done_id), 32'(id));
      step();
      check_val("done_pulse", 32'(done), 32'h0);
      check_val("busy_drop",  32'(busy), 32'h0);
      check_val("bcd_hold",   32'(bcd),  32'(exp));
    end
  endtask

  task automatic run_single(input bit id, input logic [BIN_W-1:0] v);
    request(id, v);
    wait_ack(id);
    wait_done(to_bcd(int'(v)), id, 17);
  endtask

  initial begin
    logic [BIN_W-1:0] corners [8];
    logic [BIN_W-1:0] v0, v1, v_orig;
    int unsigned      sel;
    bit               g;

    corners[0] = 17'd0;     corners[1] = 17'd1;
    corners[2] = 17'd9;     corners[3] = 17'd10;
    corners[4] = 17'd99999; corners[5] = 17'd100000;
    corners[6] = 17'd131071; corners[7] = 17'd65535;
    bin0 = '0;
    bin1 = '0;
    do_reset();

    // Basic conversions from requester 0
    run_single(1'b0, 17'd0);
    run_single(1'b0, 17'd12345);
    run_single(1'b0, 17'd131071);
    run_single(1'b0, 17'd99999);

    // Simultaneous requests after reset: req0 first, then req1
    do_reset();
    request(1'b0, 17'd1);
    request(1'b1, 17'd2);
    wait_ack(1'b0);
    wait_done(to_bcd(1), 1'b0, 17);
    wait_ack(1'b1);
    wait_done(to_bcd(2), 1'b1, 17);

    // Last grant was req1, so req0 wins the next tie
    request(1'b0, 17'd777);
    request(1'b1, 17'd31);
    wait_ack(1'b0);
    wait_done(to_bcd(777), 1'b0, 17);
    wait_ack(1'b1);
    wait_done(to_bcd(31), 1'b1, 17);

    // Request arriving mid-conversion waits; bin0 changes must not leak in
    v_orig = 17'd54321;
    request(1'b0, v_orig);
    wait_ack(1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("mid_no_ack", 32'({ack1, ack0}), 32'h0);
    end
    request(1'b1, 17'd42);
    bin0 = 17'd11111;
    wait_done(to_bcd(int'(v_orig)), 1'b0, 12);
    wait_ack(1'b1);
    wait_done(to_bcd(42), 1'b1, 17);

    // Reset in the middle of a conversion aborts it
    request(1'b0, 17'd8888);
    wait_ack(1'b0);
    for (int i = 0; i < 8; i++) step();
    reset = 1'b0;
    #1;
    check_val("abort_bcd",  32'(bcd),  32'h0);
    check_val("abort_busy", 32'(busy), 32'h0);
    check_val("abort_done", 32'(done), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("abort_no_done", 32'(done), 32'h0);
    end
    reset = 1'b1;
    pref  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_val("post_abort_quiet", 32'({done, busy}), 32'h0);
    end
    run_single(1'b1, 17'd65535);

    // Randomized jobs, single and contending
    for (int it = 0; it < 24; it++) begin
      sel = $urandom_range(1, 3);
      v0  = ($urandom_range(0, 1) != 0) ? BIN_W'($urandom_range(0, 131071)) : corners[$urandom_range(0, 7)];
      v1  = ($urandom_range(0, 1) != 0) ? BIN_W'($urandom_range(0, 131071)) : corners[$urandom_range(0, 7)];
      if (sel[0]) request(1'b0, v0);
      if (sel[1]) request(1'b1, v1);
      g = (sel == 3) ? pref : sel[1];
      wait_ack(g);
      wait_done(to_bcd(int'(g ? v1 : v0)), g, 17);
      if (sel == 3) begin
        wait_ack(!g);
        wait_done(to_bcd(int'(g ? v0 : v1)), !g, 17);
      end
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
